// File: rtl/intf_stream_tx_if.sv
// Valid/ready stream link shared between a transmitter and its receiver.
interface stream_intf #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready;

    modport tx (output valid, output data, output last, input ready);
    modport rx (input valid, input data, input last, output ready);
endinterface

// File: rtl/intf_stream_tx.sv
// Stream transmitter: buffers pushed words in a small FIFO and drives them
// onto a stream_intf link with a per-packet 'last' marker.
module intf_stream_tx #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             flush,
    stream_intf.tx           tx,
    output logic [15:0]      sent_count,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [BW-1:0]    beat_cnt, beat_nxt;
    logic             push_acc, pop_acc, empty_nxt, full_nxt;
    logic [WIDTH-1:0] head_nxt;

    assign push_acc = push_valid && push_ready && !flush;
    assign pop_acc  = tx.valid && tx.ready;
    assign busy     = (state == STREAM);

    // Next-state view of the FIFO so every tx output can be registered.
    // The head word comes from push_data when the slot being written now
    // becomes the head after this edge (push into an empty or draining FIFO).
    always_comb begin
        wr_nxt   = wr_ptr;
        rd_nxt   = rd_ptr;
        beat_nxt = beat_cnt;
        if (flush) begin
            wr_nxt   = '0;
            rd_nxt   = '0;
            beat_nxt = '0;
        end else begin
            if (push_acc)
                wr_nxt = wr_ptr + 1'b1;
            if (pop_acc) begin
                rd_nxt   = rd_ptr + 1'b1;
                beat_nxt = (beat_cnt == BW'(PKT_LEN - 1)) ? '0 : beat_cnt + 1'b1;
            end
        end
        empty_nxt = (wr_nxt == rd_nxt);
        full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        head_nxt  = mem[rd_nxt[AW-1:0]];
        if (push_acc && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
            head_nxt = push_data;
        state_nxt = (flush || (empty_nxt && beat_nxt == '0)) ? IDLE : STREAM;
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointers, packet tracker and registered tx / push-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            state      <= IDLE;
            sent_count <= '0;
            push_ready <= 1'b0;
            tx.valid   <= 1'b0;
            tx.data    <= '0;
            tx.last    <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            beat_cnt   <= beat_nxt;
            state      <= state_nxt;
            sent_count <= sent_count + {15'd0, pop_acc};
            push_ready <= !full_nxt;
            tx.valid   <= !empty_nxt;
            tx.last    <= !empty_nxt && (beat_nxt == BW'(PKT_LEN - 1));
            if (!empty_nxt)
                tx.data <= head_nxt;
        end
    end
endmodule

// File: tb/tb_intf_stream_tx.sv
// Directed bench for intf_stream_tx (WIDTH=8, DEPTH=4, PKT_LEN=4).
module tb_intf_stream_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = '0;
    logic       push_ready;
    logic       flush = 1'b0;
    logic [15:0] sent_count;
    logic       busy;
    int total = 0;
    int bad = 0;

    stream_intf #(.WIDTH(8)) sif ();

    intf_stream_tx #(.WIDTH(8), .DEPTH(4), .PKT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .flush(flush), .tx(sif),
        .sent_count(sent_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; push_valid = 1'b0; push_data = '0; flush = 1'b0; sif.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_valid = 1'b0; flush = 1'b0; sif.ready = 1'b0;
        #3;
        total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sif.valid); end
        total++; if (sif.data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", sif.data); end
        total++; if (sif.last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", sif.last); end
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL rst_push_ready got=%b exp=0", push_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL rst_sent got=%0d exp=0", sent_count); end
        apply_reset();
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL rel_push_ready got=%b exp=0", push_ready); end
        tick();
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL first_edge_push_ready got=%b exp=1", push_ready); end
    endtask

    task automatic test_first_word();
        apply_reset(); tick();
        push_valid = 1'b1; push_data = 8'h11;
        tick();
        push_valid = 1'b0;
        total++; if (sif.valid !== 1'b1) begin bad++; $display("FAIL fw_valid got=%b exp=1", sif.valid); end
        total++; if (sif.data !== 8'h11) begin bad++; $display("FAIL fw_data got=%h exp=11", sif.data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fw_busy got=%b exp=1", busy); end
        sif.ready = 1'b1;
        tick();
        sif.ready = 1'b0;
        total++; if (sent_count !== 16'd1) begin bad++; $display("FAIL fw_sent got=%0d exp=1", sent_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fw_busy_mid_pkt got=%b exp=1", busy); end
        total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL fw_valid_drained got=%b exp=0", sif.valid); end
    endtask

    task automatic test_stream();
        apply_reset(); tick();
        sif.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1; push_data = 8'hA0 + 8'(i);
            tick();
            total++; if (sif.valid !== 1'b1 || sif.data !== 8'hA0 + 8'(i))
                begin bad++; $display("FAIL st_beat%0d got=%b/%h exp=1/%h", i, sif.valid, sif.data, 8'hA0 + 8'(i)); end
            total++; if (sif.last !== ((i % 4) == 3))
                begin bad++; $display("FAIL st_last%0d got=%b exp=%b", i, sif.last, (i % 4) == 3); end
        end
        push_valid = 1'b0;
        tick();
        sif.ready = 1'b0;
        total++; if (sent_count !== 16'd8) begin bad++; $display("FAIL st_sent got=%0d exp=8", sent_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL st_busy got=%b exp=0", busy); end
        total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL st_valid_end got=%b exp=0", sif.valid); end
    endtask

    task automatic test_backpressure();
        apply_reset(); tick();
        sif.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            tick();
            total++; if (push_ready !== (i < 4))
                begin bad++; $display("FAIL bp_push_ready%0d got=%b exp=%b", i, push_ready, i < 4); end
        end
        push_data = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (sif.data !== 8'h01 || sif.valid !== 1'b1 || sif.last !== 1'b0)
                begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/01/0", i, sif.valid, sif.data, sif.last); end
            total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%b exp=0", i, push_ready); end
        end
        sif.ready = 1'b1;
        tick();
        total++; if (sif.data !== 8'h02) begin bad++; $display("FAIL bp_d2 got=%h exp=02", sif.data); end
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b exp=1", push_ready); end
        tick();
        push_valid = 1'b0;
        total++; if (sif.data !== 8'h03) begin bad++; $display("FAIL bp_d3 got=%h exp=03", sif.data); end
        tick();
        total++; if (sif.data !== 8'h04 || sif.last !== 1'b1)
            begin bad++; $display("FAIL bp_d4 got=%h/%b exp=04/1", sif.data, sif.last); end
        tick();
        total++; if (sif.data !== 8'h05 || sif.last !== 1'b0)
            begin bad++; $display("FAIL bp_d5 got=%h/%b exp=05/0", sif.data, sif.last); end
        tick();
        sif.ready = 1'b0;
        total++; if (sif.valid !== 1'b0 || sent_count !== 16'd5)
            begin bad++; $display("FAIL bp_end got=%b/%0d exp=0/5", sif.valid, sent_count); end
    endtask

    task automatic test_full_pop();
        apply_reset(); tick();
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = 8'h21 + 8'(i);
            tick();
        end
        push_data = 8'h66; sif.ready = 1'b1;
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fp_ready_full got=%b exp=0", push_ready); end
        tick();
        push_valid = 1'b0; sif.ready = 1'b0;
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fp_ready_after got=%b exp=1", push_ready); end
        total++; if (sif.data !== 8'h22 || sent_count !== 16'd1)
            begin bad++; $display("FAIL fp_head got=%h/%0d exp=22/1", sif.data, sent_count); end
        sif.ready = 1'b1;
        tick(); tick();
        total++; if (sif.valid !== 1'b1 || sif.data !== 8'h24)
            begin bad++; $display("FAIL fp_occ3 got=%b/%h exp=1/24", sif.valid, sif.data); end
        tick();
        sif.ready = 1'b0;
        total++; if (sif.valid !== 1'b0 || sent_count !== 16'd4)
            begin bad++; $display("FAIL fp_drained got=%b/%0d exp=0/4", sif.valid, sent_count); end
    endtask

    task automatic test_flush();
        apply_reset(); tick();
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = 8'h31 + 8'(i);
            tick();
        end
        push_data = 8'h35; sif.ready = 1'b1;
        tick(); tick();
        total++; if (sif.data !== 8'h33 || sent_count !== 16'd2)
            begin bad++; $display("FAIL fl_pre got=%h/%0d exp=33/2", sif.data, sent_count); end
        push_data = 8'h99; flush = 1'b1;
        tick();
        flush = 1'b0; push_valid = 1'b0; sif.ready = 1'b0;
        total++; if (sif.valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", sif.valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fl_busy got=%b exp=0", busy); end
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fl_push_ready got=%b exp=1", push_ready); end
        total++; if (sent_count !== 16'd3) begin bad++; $display("FAIL fl_sent got=%0d exp=3", sent_count); end
        push_valid = 1'b1; push_data = 8'h55;
        tick();
        push_valid = 1'b0;
        tick();
        total++; if (sif.valid !== 1'b1 || sif.data !== 8'h55 || sif.last !== 1'b0)
            begin bad++; $display("FAIL fl_restart got=%b/%h/%b exp=1/55/0", sif.valid, sif.data, sif.last); end
        sif.ready = 1'b1;
        tick();
        sif.ready = 1'b0;
        total++; if (sif.valid !== 1'b0 || sent_count !== 16'd4 || busy !== 1'b1)
            begin bad++; $display("FAIL fl_after got=%b/%0d/%b exp=0/4/1", sif.valid, sent_count, busy); end
    endtask

    task automatic test_async_reset();
        apply_reset(); tick();
        push_valid = 1'b1; push_data = 8'h41;
        tick();
        push_data = 8'h42; sif.ready = 1'b1;
        tick();
        push_valid = 1'b0; sif.ready = 1'b0;
        total++; if (sif.valid !== 1'b1 || sif.data !== 8'h42 || sent_count !== 16'd1)
            begin bad++; $display("FAIL ar_pre got=%b/%h/%0d exp=1/42/1", sif.valid, sif.data, sent_count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (sif.valid !== 1'b0 || sent_count !== 16'd0 || push_ready !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL ar_async got=%b/%0d/%b/%b exp=0/0/0/0", sif.valid, sent_count, push_ready, busy); end
        #1 rst_n = 1'b1;
        tick();
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL ar_push_ready got=%b exp=1", push_ready); end
        sif.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = 8'h43 + 8'(i);
            tick();
            total++; if (sif.data !== 8'h43 + 8'(i) || sif.last !== (i == 3))
                begin bad++; $display("FAIL ar_beat%0d got=%h/%b exp=%h/%b", i, sif.data, sif.last, 8'h43 + 8'(i), i == 3); end
        end
        push_valid = 1'b0;
        tick();
        sif.ready = 1'b0;
        total++; if (sent_count !== 16'd4 || busy !== 1'b0)
            begin bad++; $display("FAIL ar_end got=%0d/%b exp=4/0", sent_count, busy); end
    endtask

    initial begin
        sif.ready = 1'b0;
        test_reset();
        test_first_word();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intf_stream_tx.md
Name: intf_stream_tx

Overview:
- Transmit (writer) end of a parameterised valid/ready stream interface `stream_intf`.
- Accepts words on a local push port and buffers them in a small FIFO.
- Drives them out through an interface port, using modport `tx`, with a packet-boundary `last` flag.
- Instantiated inside generate blocks next to the matching receiver; the interface instance is shared between the two.

Parameters:
- WIDTH, 8, data width; must equal the `stream_intf` WIDTH parameter of the connected instance.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PKT_LEN, 4, beats per packet; `last` is asserted on beat PKT_LEN-1; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_valid  input  1  local word offered.
- push_data  input  WIDTH  local word.
- push_ready  output  1  FIFO can accept a word.
- flush  input  1  synchronous discard of buffered words and packet position.
- tx  interface  stream_intf.tx  members:
  - valid out 1
  - data out WIDTH
  - last out 1
  - ready in 1
- sent_count  output  16  completed tx beats, wrapping.
- busy  output  1  FIFO non-empty or packet in progress.

Behaviour:
- Reset (rst_n low, async): all of the following, held until the first rising clk edge after rst_n goes high:
  - FIFO empty; rd/wr pointers 0
  - beat_cnt 0; sent_count 0
  - tx.valid 0, tx.data 0, tx.last 0
  - push_ready 0; busy 0
- push_ready is registered: it becomes 1 on the first edge after reset release. Thereafter it is !full computed for the next state.
- Push handshake: a word is stored when push_valid && push_ready at the edge. There is no bypass, so when the FIFO is full push_ready=0 even if tx pops in the same cycle.
- Output: tx.valid = FIFO non-empty, tx.data = head entry, tx.last = (beat_cnt == PKT_LEN-1) && tx.valid. All three are driven from registers, not from combinational input paths.
- Latency: a word pushed at edge N is visible on tx at N+1 (FIFO was empty, tx.ready ignored).
- Stability: while tx.valid=1 and tx.ready=0, tx.data and tx.last hold. tx.valid never drops without a handshake, except on flush or reset.
- Pop handshake: a beat completes when tx.valid && tx.ready at the edge. On completion:
  - the head is removed
  - sent_count increments (65535 -> 0)
  - beat_cnt increments, wrapping PKT_LEN-1 -> 0
- Simultaneous push and pop (FIFO not full): occupancy unchanged, pointers both advance.
- Pointer wrap: pointers are log2(DEPTH)+1 bits, and the extra MSB distinguishes full from empty.
- State machine (packet tracker):
  - IDLE: beat_cnt==0 and FIFO empty.
  - STREAM: otherwise.
  - IDLE -> STREAM on any accepted push.
  - STREAM -> IDLE when the FIFO becomes empty and beat_cnt returns to 0 in the same edge, or on flush.
  - busy = (state==STREAM).
- Flush (synchronous, highest priority after reset):
  - FIFO emptied, beat_cnt 0, state IDLE.
  - A push in the same cycle is dropped.
  - A tx handshake in the same cycle still counts in sent_count.
  - tx.valid is 0 from the next cycle.
  - push_ready is 1 the next cycle.
- Mid-operation reset: immediate return to reset values. Partially sent packets are abandoned with no `last` emitted.
- X rules: push_data is not sampled unless push_valid=1. tx.ready is ignored while tx.valid=0.

Test Plan:
- Reset release, WIDTH=8, DEPTH=4, PKT_LEN=4:
  - push 0x11 at cycle 2 -> tx.valid=1, tx.data=0x11 at cycle 3.
  - tx.ready=1 -> sent_count=1, busy=1 (beat_cnt=1).
- Push 0xA0..0xA7 with tx.ready=1 continuously:
  - tx beats in order A0..A7.
  - tx.last=1 exactly on A3 and A7.
  - sent_count=8, busy=0 afterwards.
- Back-pressure, tx.ready=0, push 0x01..0x05:
  - push_ready drops to 0 after the 4th accepted word; 0x05 is held off.
  - tx.data stays 0x01 for all stalled cycles.
  - Raise ready -> 0x01..0x05 delivered in order.
- Full FIFO with simultaneous pop:
  - push_ready=0 that cycle.
  - Next cycle push_ready=1, occupancy 3.
- Flush after 2 beats of a packet with 3 words buffered:
  - tx.valid=0 next cycle, busy=0.
  - Next pushed word 0x55 emits with tx.last=0 at beat 0; the packet restarts.
- Assert rst_n=0 mid-packet for less than one clock period:
  - tx.valid, sent_count and push_ready go to 0 without waiting for a clock edge.
  - After release, the stream restarts with beat_cnt=0.
